// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port.
// One transaction at a time, data before fetch, flushed fetches are drained.
module mem_arbiter #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    input  logic                 i_flush,
    output logic                 i_ready,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_stall,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ready,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_D,
        BUSY_I,
        BUSY_DROP,
        RESP_D,
        RESP_I
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_grant_d;
    logic                 w_grant_i;
    logic                 w_capture_d;
    logic                 w_capture_i;

    logic                 r_mem_we;
    logic [WORD_SIZE-1:0] r_mem_addr;
    logic [WORD_SIZE-1:0] r_mem_wdata;
    logic [WORD_SIZE-1:0] r_i_rdata;
    logic [WORD_SIZE-1:0] r_d_rdata;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a latch behind.
    always_comb begin
        w_next_state = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        w_capture_d  = 1'b0;
        w_capture_i  = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_req) begin
                    w_grant_d    = 1'b1;
                    w_next_state = BUSY_D;
                end else if (i_req && !i_flush) begin
                    w_grant_i    = 1'b1;
                    w_next_state = BUSY_I;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    w_capture_d  = !r_mem_we;
                    w_next_state = RESP_D;
                end
            end
            BUSY_I: begin
                // A squashed fetch must still be drained: memory cannot abort.
                if (i_flush) begin
                    w_next_state = mem_ack ? IDLE : BUSY_DROP;
                end else if (mem_ack) begin
                    w_capture_i  = 1'b1;
                    w_next_state = RESP_I;
                end
            end
            BUSY_DROP: begin
                if (mem_ack) begin
                    w_next_state = IDLE;
                end
            end
            RESP_D:  w_next_state = IDLE;
            RESP_I:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            if (w_grant_d) begin
                r_mem_we    <= d_we;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
            end else if (w_grant_i) begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= i_addr;
            end
            if (w_capture_d) begin
                r_d_rdata <= mem_rdata;
            end
            if (w_capture_i) begin
                r_i_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = (r_state == BUSY_D) || (r_state == BUSY_I) || (r_state == BUSY_DROP);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // A flush arriving in the response cycle still suppresses the fetch.
    assign i_ready   = (r_state == RESP_I) && !i_flush;
    assign d_ready   = (r_state == RESP_D);
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

    assign i_stall   = i_req & ~i_ready;
    assign d_stall   = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// two-requester run checked against a word-array reference memory.
module tb_mem_arbiter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_req, i_flush, i_ready, i_stall;
    logic [W-1:0] i_addr, i_rdata;
    logic         d_req, d_we, d_ready, d_stall;
    logic [W-1:0] d_addr, d_wdata, d_rdata;
    logic         mem_req, mem_we, mem_ack;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

    logic         mem_ack_m;
    logic         ack_inject;
    logic [W-1:0] mem_arr [0:255];
    logic [W-1:0] ref_mem [0:255];
    int           mem_lat;
    logic         rand_lat;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] exp_i_rdata;
    logic [W-1:0] exp_d_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.WORD_SIZE(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_flush   (i_flush),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .i_stall   (i_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    assign mem_ack = mem_ack_m | ack_inject;

    function automatic logic [W-1:0] init_word(int a);
        if (a == 16) return 16'h6A05;
        return 16'(a * 16'h0137 + 16'h2400);
    endfunction

    // Memory: acks in the lat-th cycle of mem_req; junk data otherwise.
    initial begin : mem_model
        int cnt;
        int lat;
        for (int a = 0; a < 256; a++) mem_arr[a] = init_word(a);
        mem_ack_m = 1'b0;
        mem_rdata = '0;
        cnt = 0;
        lat = 1;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req) begin
                if (cnt == 0) lat = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
                cnt++;
                if (cnt >= lat) begin
                    mem_ack_m = 1'b1;
                    mem_rdata = mem_arr[mem_addr[7:0]];
                    if (mem_we) mem_arr[mem_addr[7:0]] = mem_wdata;
                    cnt = 0;
                end else begin
                    mem_ack_m = 1'b0;
                    mem_rdata = 16'($urandom);
                end
            end else begin
                mem_ack_m = 1'b0;
                mem_rdata = 16'($urandom);
                cnt = 0;
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, i_ready, d_ready} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0000", {mem_req, mem_we, i_ready, d_ready});
        end
        checks++;
        if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, i_rdata, d_rdata});
        end
        checks++;
        if ({i_stall, d_stall} !== 2'b10) begin
            errors++; $display("FAIL reset_stall: got %b want 10", {i_stall, d_stall});
        end
        drive_edge();
        i_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL reset_release_idle: mem_req got %b want 0", mem_req);
        end
    endtask

    task automatic test_fetch();
        mem_lat = 1;
        drive_edge();
        i_req = 1'b1; i_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if ({i_stall, mem_req} !== 2'b10) begin
            errors++; $display("FAIL fetch_c0: stall,req got %b want 10", {i_stall, mem_req});
        end
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, i_ready, i_stall} !== {2'b10, 16'h0010, 2'b01}) begin
            errors++; $display("FAIL fetch_c1: got %b/%b/%h/%b/%b", mem_req, mem_we, mem_addr, i_ready, i_stall);
        end
        @(negedge clk);
        checks++;
        if ({i_ready, i_stall, i_rdata} !== {2'b10, 16'h6A05}) begin
            errors++; $display("FAIL fetch_c2: ready,stall,rdata got %b/%b/%h want 1/0/6a05", i_ready, i_stall, i_rdata);
        end
        drive_edge();
        i_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({i_ready, mem_req} !== 2'b00) begin
            errors++; $display("FAIL fetch_pulse: ready,req got %b want 00", {i_ready, mem_req});
        end
        exp_i_rdata = 16'h6A05;
    endtask

    task automatic test_simultaneous();
        int t_d, t_i, n_d;
        t_d = -1; t_i = -1; n_d = 0;
        mem_lat = 3;
        drive_edge();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0080;
        i_req = 1'b1; i_addr = 16'h0011;
        for (int c = 0; c < 40 && t_i < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if ({mem_req, mem_we, mem_addr} !== {2'b10, 16'h0080}) begin
                    errors++; $display("FAIL sim_data_first: got %b/%b/%h want 1/0/0080", mem_req, mem_we, mem_addr);
                end
            end
            if (t_d >= 0 && c == t_d + 2) begin
                checks++;
                if ({mem_req, mem_we, mem_addr} !== {2'b10, 16'h0011}) begin
                    errors++; $display("FAIL sim_fetch_grant: got %b/%b/%h want 1/0/0011", mem_req, mem_we, mem_addr);
                end
            end
            if (d_ready) begin
                n_d++; t_d = c;
                checks++;
                if (d_rdata !== ref_mem[8'h80]) begin
                    errors++; $display("FAIL sim_d_rdata: got %h want %h", d_rdata, ref_mem[8'h80]);
                end
            end
            if (i_ready) begin
                t_i = c;
                checks++;
                if (i_rdata !== ref_mem[8'h11]) begin
                    errors++; $display("FAIL sim_i_rdata: got %h want %h", i_rdata, ref_mem[8'h11]);
                end
            end
            drive_edge();
            if (t_d == c) d_req = 1'b0;
            if (t_i == c) i_req = 1'b0;
        end
        d_req = 1'b0; i_req = 1'b0;
        checks++;
        if (t_d != 4) begin
            errors++; $display("FAIL sim_d_latency: d_ready at cycle %0d want 4", t_d);
        end
        checks++;
        if (t_i - t_d != 5) begin
            errors++; $display("FAIL sim_i_after_d: gap %0d want 5 (t_i=%0d)", t_i - t_d, t_i);
        end
        checks++;
        if (n_d != 1) begin
            errors++; $display("FAIL sim_d_once: d_ready pulses %0d want 1", n_d);
        end
        exp_d_rdata = ref_mem[8'h80];
        exp_i_rdata = ref_mem[8'h11];
    endtask

    task automatic test_store();
        int n_d, n_busy;
        n_d = 0; n_busy = 0;
        mem_lat = 2;
        drive_edge();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
        for (int c = 0; c < 20 && n_d == 0; c++) begin
            @(negedge clk);
            if (mem_req) begin
                n_busy++;
                checks++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0040, 16'hBEEF}) begin
                    errors++; $display("FAIL store_bus: got %b/%h/%h want 1/0040/beef", mem_we, mem_addr, mem_wdata);
                end
            end
            if (d_ready) n_d++;
            drive_edge();
            if (n_d > 0) begin
                d_req = 1'b0; d_we = 1'b0;
            end
        end
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        if (d_ready) n_d++;
        ref_mem[8'h40] = 16'hBEEF;
        checks++;
        if (n_d != 1 || n_busy != 2) begin
            errors++; $display("FAIL store_ready: pulses %0d busy %0d want 1 and 2", n_d, n_busy);
        end
        checks++;
        if (d_rdata !== exp_d_rdata) begin
            errors++; $display("FAIL store_d_rdata: got %h want %h", d_rdata, exp_d_rdata);
        end
        checks++;
        if (mem_arr[8'h40] !== 16'hBEEF) begin
            errors++; $display("FAIL store_written: memory got %h want beef", mem_arr[8'h40]);
        end
    endtask

    task automatic test_flush_mid_fetch();
        int got;
        mem_lat = 3;
        drive_edge();
        i_req = 1'b1; i_addr = 16'h0030;
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            drive_edge();
            i_flush = (c == 1);
            if (c == 1) i_req = 1'b0;
            @(negedge clk);
            checks++;
            if ({mem_req, i_ready} !== 2'b10) begin
                errors++; $display("FAIL flush_drain_c%0d: req,ready got %b want 10", c, {mem_req, i_ready});
            end
        end
        drive_edge();
        i_req = 1'b1; i_addr = 16'h0020;
        @(negedge clk);
        checks++;
        if ({mem_req, i_ready, i_rdata} !== {2'b00, exp_i_rdata}) begin
            errors++; $display("FAIL flush_done: got %b/%b/%h want 0/0/%h", mem_req, i_ready, i_rdata, exp_i_rdata);
        end
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {2'b10, 16'h0020}) begin
            errors++; $display("FAIL flush_regrant: got %b/%b/%h want 1/0/0020", mem_req, mem_we, mem_addr);
        end
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clk);
            if (i_ready) got = 1;
        end
        checks++;
        if (got == 0 || i_rdata !== ref_mem[8'h20]) begin
            errors++; $display("FAIL flush_next_fetch: ready %0d rdata %h want 1 and %h", got, i_rdata, ref_mem[8'h20]);
        end
        drive_edge();
        i_req = 1'b0;
        exp_i_rdata = ref_mem[8'h20];
        // Flush in the very cycle the memory acks: straight back to IDLE.
        mem_lat = 1;
        drive_edge();
        i_req = 1'b1; i_addr = 16'h0031;
        @(negedge clk);
        drive_edge();
        i_flush = 1'b1; i_req = 1'b0;
        @(negedge clk);
        drive_edge();
        i_flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, i_ready, i_rdata} !== {2'b00, exp_i_rdata}) begin
            errors++; $display("FAIL flush_with_ack: got %b/%b/%h want 0/0/%h", mem_req, i_ready, i_rdata, exp_i_rdata);
        end
    endtask

    task automatic test_flush_resp_and_grant();
        int n_req;
        mem_lat = 1;
        drive_edge();
        i_req = 1'b1; i_addr = 16'h0012;
        @(negedge clk);
        @(negedge clk);
        drive_edge();
        i_flush = 1'b1;
        @(negedge clk);
        checks++;
        if ({i_ready, i_stall} !== 2'b01) begin
            errors++; $display("FAIL flush_resp: ready,stall got %b want 01", {i_ready, i_stall});
        end
        drive_edge();
        i_flush = 1'b0; i_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({i_ready, i_rdata} !== {1'b0, ref_mem[8'h12]}) begin
            errors++; $display("FAIL flush_resp_after: got %b/%h want 0/%h", i_ready, i_rdata, ref_mem[8'h12]);
        end
        exp_i_rdata = ref_mem[8'h12];
        drive_edge();
        i_req = 1'b1; i_addr = 16'h0013; i_flush = 1'b1;
        n_req = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mem_req || i_ready) n_req++;
            drive_edge();
            i_req = 1'b0; i_flush = 1'b0;
        end
        checks++;
        if (n_req != 0) begin
            errors++; $display("FAIL flush_at_grant: %0d cycles with mem_req/i_ready want 0", n_req);
        end
    endtask

    task automatic test_spurious_ack();
        drive_edge();
        ack_inject = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({mem_req, i_ready, d_ready, i_rdata, d_rdata} !== {3'b000, exp_i_rdata, exp_d_rdata}) begin
                errors++; $display("FAIL spurious_ack_c%0d: got %b%b%b/%h/%h", c, mem_req, i_ready, d_ready, i_rdata, d_rdata);
            end
            drive_edge();
        end
        ack_inject = 1'b0;
    endtask

    task automatic test_reset_mid();
        int got;
        mem_lat = 20;
        drive_edge();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0090;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0090}) begin
            errors++; $display("FAIL rstmid_busy: got %b/%h want 1/0090", mem_req, mem_addr);
        end
        drive_edge();
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_we, d_ready, i_ready, d_stall} !== 5'b00001) begin
            errors++; $display("FAIL rstmid_ctrl: got %b want 00001", {mem_req, mem_we, d_ready, i_ready, d_stall});
        end
        checks++;
        if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 64'h0) begin
            errors++; $display("FAIL rstmid_data: got %h want 0", {mem_addr, mem_wdata, i_rdata, d_rdata});
        end
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        mem_lat = 2;
        drive_edge();
        reset = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clk);
            if (d_ready) got = 1;
        end
        checks++;
        if (got == 0 || d_rdata !== ref_mem[8'h90]) begin
            errors++; $display("FAIL rstmid_fresh: ready %0d rdata %h want 1 and %h", got, d_rdata, ref_mem[8'h90]);
        end
        drive_edge();
        d_req = 1'b0;
        exp_d_rdata = ref_mem[8'h90];
    endtask

    task automatic test_random();
        bit f_done, d_done;
        f_done = 1'b0; d_done = 1'b0;
        rand_lat = 1'b1;
        fork
            begin : fetch_side
                logic [W-1:0] a;
                int got;
                drive_edge();
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) drive_edge();
                    a = 16'($urandom_range(0, 127));
                    i_req = 1'b1; i_addr = a;
                    got = 0;
                    for (int w = 0; w < 100 && got == 0; w++) begin
                        @(negedge clk);
                        if (i_ready) got = 1;
                    end
                    checks++;
                    if (got == 0 || i_rdata !== ref_mem[a[7:0]]) begin
                        errors++; $display("FAIL rnd_fetch %0d: ready %0d addr %h got %h want %h", k, got, a, i_rdata, ref_mem[a[7:0]]);
                    end
                    drive_edge();
                    i_req = 1'b0;
                end
                f_done = 1'b1;
            end
            begin : data_side
                logic [W-1:0] a, wd;
                logic         we;
                int           got;
                drive_edge();
                for (int k = 0; k < 25; k++) begin
                    repeat ($urandom_range(0, 3)) drive_edge();
                    we = 1'($urandom_range(0, 1));
                    a  = we ? 16'($urandom_range(128, 255)) : 16'($urandom_range(0, 255));
                    wd = 16'($urandom);
                    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
                    got = 0;
                    for (int w = 0; w < 100 && got == 0; w++) begin
                        @(negedge clk);
                        if (d_ready) got = 1;
                    end
                    if (!we) exp_d_rdata = ref_mem[a[7:0]];
                    checks++;
                    if (got == 0 || d_rdata !== exp_d_rdata) begin
                        errors++; $display("FAIL rnd_data %0d: ready %0d we %b addr %h got %h want %h", k, got, we, a, d_rdata, exp_d_rdata);
                    end
                    if (we) ref_mem[a[7:0]] = wd;
                    drive_edge();
                    d_req = 1'b0; d_we = 1'b0;
                end
                d_done = 1'b1;
            end
            begin : monitor
                logic         p_mem_req, p_d_req, p_i_req, p_d_we;
                logic [W-1:0] p_d_addr, p_i_addr;
                logic [17:0]  exp_grant;
                p_mem_req = 1'b0; p_d_req = 1'b0; p_i_req = 1'b0; p_d_we = 1'b0;
                p_d_addr = '0; p_i_addr = '0;
                for (int n = 0; n < 6000 && !(f_done && d_done); n++) begin
                    @(negedge clk);
                    checks++;
                    if ({i_stall, d_stall} !== {i_req & ~i_ready, d_req & ~d_ready}) begin
                        errors++; $display("FAIL rnd_stall: got %b want %b", {i_stall, d_stall}, {i_req & ~i_ready, d_req & ~d_ready});
                    end
                    if (mem_req && !p_mem_req) begin
                        if (p_d_req)      exp_grant = {1'b1, p_d_we, p_d_addr};
                        else if (p_i_req) exp_grant = {1'b1, 1'b0, p_i_addr};
                        else              exp_grant = '0;
                        checks++;
                        if ({1'b1, mem_we, mem_addr} !== exp_grant) begin
                            errors++; $display("FAIL rnd_grant: got %h want %h", {1'b1, mem_we, mem_addr}, exp_grant);
                        end
                    end
                    p_mem_req = mem_req; p_d_req = d_req; p_i_req = i_req;
                    p_d_we = d_we; p_d_addr = d_addr; p_i_addr = i_addr;
                end
                if (!(f_done && d_done)) begin
                    checks++; errors++;
                    $display("FAIL rnd_timeout: fetch_done %b data_done %b", f_done, d_done);
                end
            end
        join
        rand_lat = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        ack_inject = 1'b0; mem_lat = 1; rand_lat = 1'b0;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_word(a);
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        test_reset();
        test_fetch();
        test_simultaneous();
        test_store();
        test_flush_mid_fetch();
        test_flush_resp_and_grant();
        test_spurious_ack();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported unified memory between the pipeline's instruction-fetch port and the MEM-stage data port. Performs one memory transaction at a time through a request/acknowledge handshake to the memory. Returns a one-cycle ready pulse to the winning requester and raises stall signals that the pipeline uses to freeze its stages. Data accesses take priority over fetches, and a fetch squashed by a taken branch or jump is drained without being delivered.

## Interface
Parameters:
- WORD_SIZE, 16, address and data width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr stable until i_ready
- i_addr  in  WORD_SIZE  fetch address
- i_flush  in  1  one-cycle pulse that squashes the outstanding or pending fetch
- i_ready  out  1  one-cycle pulse; i_rdata valid
- i_rdata  out  WORD_SIZE  fetched instruction (registered)
- i_stall  out  1  i_req & ~i_ready
- d_req  in  1  data request; held with d_we, d_addr and d_wdata stable until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  WORD_SIZE  data address
- d_wdata  in  WORD_SIZE  store data
- d_ready  out  1  one-cycle pulse; access complete, d_rdata valid for reads
- d_rdata  out  WORD_SIZE  load data (registered)
- d_stall  out  1  d_req & ~d_ready
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  write enable (registered at grant)
- mem_addr  out  WORD_SIZE  address (registered at grant)
- mem_wdata  out  WORD_SIZE  write data (registered at grant)
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle
- mem_rdata  in  WORD_SIZE  memory read data

## Operation
- FSM states: IDLE, BUSY_D, BUSY_I, BUSY_DROP, RESP_D, RESP_I.
- IDLE with d_req: latch d_we, d_addr and d_wdata into mem_*; go to BUSY_D. This takes priority over i_req.
- IDLE with i_req, no d_req and no i_flush: latch i_addr into mem_addr with mem_we=0; go to BUSY_I.
- IDLE with i_req and i_flush in the same cycle: no grant; stay in IDLE.
- BUSY_D with mem_ack: capture mem_rdata into d_rdata (only when mem_we=0); go to RESP_D.
- BUSY_I with mem_ack and no i_flush: capture mem_rdata into i_rdata; go to RESP_I.
- BUSY_I with i_flush: go to BUSY_DROP. If mem_ack arrives in the same cycle, go directly to IDLE and leave i_rdata unchanged.
- BUSY_DROP: keep mem_req high until mem_ack, then go to IDLE. Memory cannot abort a transaction. No i_ready is produced.
- RESP_D: d_ready=1 for one cycle; go to IDLE. No new grant is made in this cycle, so the requester's still-high req cannot be re-granted.
- RESP_I: i_ready=1 unless i_flush is high in this cycle, in which case i_ready=0. Go to IDLE either way.
- mem_req=1 exactly in BUSY_D, BUSY_I and BUSY_DROP.
- mem_we, mem_addr and mem_wdata hold their values from grant until the next grant.
- i_rdata and d_rdata hold their values until the next capture. A write leaves d_rdata unchanged.
- d-side traffic is never affected by i_flush.
- No starvation guard is provided. The pipeline issues at most one data request per instruction, so fetches always progress.

## Timing
- Reset (asynchronous, any state): state=IDLE; mem_req, mem_we, i_ready and d_ready = 0; mem_addr, mem_wdata, i_rdata and d_rdata = 0.
- Reset mid-transaction abandons that transaction. The memory model must tolerate mem_req dropping before mem_ack.
- i_stall and d_stall are combinational from req/ready and are valid during reset.
- Request sampled in IDLE at cycle 0: mem_req high from cycle 1.
- mem_ack at cycle k ≥ 1 gives ready at cycle k+1. The minimum request-to-ready latency is 2 cycles.
- Back-to-back: after RESP_x at cycle r, the next grant is sampled at r+1 and mem_req rises at r+2.
- mem_ack outside the BUSY states is ignored.

## Test plan
- Fetch only: i_req, i_addr=0x0010, and the memory acks in its first mem_req cycle with 0x6A05. Required: mem_addr=0x0010, mem_we=0; i_ready pulses at cycle 2 with i_rdata=0x6A05; i_stall is high in cycles 0–1.
- Simultaneous requests: d_req (read 0x0080) and i_req (0x0011) in the same IDLE cycle, memory latency 3. Required: data is served first and d_ready pulses once with d_rdata=mem value. The fetch is then granted with mem_addr=0x0011, and i_ready arrives 5 cycles after the data ready.
- Store: d_we=1, d_addr=0x0040, d_wdata=0xBEEF. Required: mem_we=1 and mem_wdata=0xBEEF while mem_req is high; d_ready pulses once; d_rdata is unchanged.
- Flush mid-fetch: i_flush is pulsed while in BUSY_I and mem_ack arrives 2 cycles later. Required: mem_req stays high until the ack; no i_ready; i_rdata is unchanged. A new i_req with i_addr=0x0020 in the following cycle is granted normally.
- Flush in RESP_I and flush at grant: Required: i_ready stays 0 in both cases; with flush at grant, mem_req never rises for that fetch.
- Reset mid-transaction: assert reset during BUSY_D. Required: mem_req, d_ready and i_ready fall to 0 immediately (asynchronously); all registers read 0; after release a fresh d_req completes normally.
